// File: rtl/tbird_light_sequencer.sv
// T-Bird tail-light sequencer with a built-in tick prescaler, a step counter,
// a mode state machine and an active-low 7-segment mode indicator.
module tbird_light_sequencer #(
  parameter int unsigned LAMPS    = 3,
  parameter int unsigned TICK_DIV = 12500000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             left_req,
  input  logic             right_req,
  input  logic             hazard_req,
  output logic [LAMPS-1:0] lamp_l,
  output logic [LAMPS-1:0] lamp_r,
  output logic [6:0]       seg
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned SW = $clog2(LAMPS + 1);

  // Segment patterns, bit order {g,f,e,d,c,b,a}, 0 = lit.
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_LEFT  = 7'b1000111;
  localparam logic [6:0] SEG_RIGHT = 7'b0101111;
  localparam logic [6:0] SEG_HAZ   = 7'b0001001;

  typedef enum logic [1:0] {
    MODE_IDLE,
    MODE_LEFT,
    MODE_RIGHT,
    MODE_HAZARD
  } mode_t;

  mode_t          mode;
  mode_t          req_mode;
  logic [PW-1:0]  presc;
  logic [SW-1:0]  step;
  logic           tick;

  // Sweep pattern: the lowest `s` lamps lit.
  function automatic logic [LAMPS-1:0] sweep(input logic [SW-1:0] s);
    logic [LAMPS-1:0] pat;
    pat = '0;
    for (int i = 0; i < int'(LAMPS); i++) begin
      pat[i] = (SW'(i) < s);
    end
    return pat;
  endfunction

  // Requested mode from the switch levels; both turn switches means hazard.
  always_comb begin
    req_mode = MODE_IDLE;
    if (hazard_req || (left_req && right_req)) begin
      req_mode = MODE_HAZARD;
    end else if (left_req) begin
      req_mode = MODE_LEFT;
    end else if (right_req) begin
      req_mode = MODE_RIGHT;
    end
  end

  assign tick = (presc == PW'(TICK_DIV - 1));

  // Mode FSM, prescaler, step counter and registered lamp/segment outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode   <= MODE_IDLE;
      step   <= '0;
      presc  <= '0;
      lamp_l <= '0;
      lamp_r <= '0;
      seg    <= SEG_DASH;
    end else begin
      if (req_mode != mode) begin
        mode  <= req_mode;
        step  <= '0;
        presc <= '0;
      end else if (mode == MODE_IDLE) begin
        step  <= '0;
        presc <= '0;
      end else begin
        presc <= tick ? '0 : presc + PW'(1);
        if (tick) begin
          if (mode == MODE_HAZARD) begin
            step <= (step == '0) ? SW'(1) : '0;
          end else begin
            step <= (step == SW'(LAMPS)) ? '0 : step + SW'(1);
          end
        end
      end

      // Outputs follow the registered mode/step, one cycle behind them.
      case (mode)
        MODE_IDLE: begin
          lamp_l <= '0;
          lamp_r <= '0;
          seg    <= SEG_DASH;
        end
        MODE_LEFT: begin
          lamp_l <= sweep(step);
          lamp_r <= '0;
          seg    <= SEG_LEFT;
        end
        MODE_RIGHT: begin
          lamp_l <= '0;
          lamp_r <= sweep(step);
          seg    <= SEG_RIGHT;
        end
        MODE_HAZARD: begin
          lamp_l <= (step != '0) ? {LAMPS{1'b1}} : '0;
          lamp_r <= (step != '0) ? {LAMPS{1'b1}} : '0;
          seg    <= SEG_HAZ;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tbird_light_sequencer.sv
// Bench for tbird_light_sequencer: cycle-count reference model compared every
// cycle, plus hand-computed literal checks along the directed scenarios.
module tb_tbird_light_sequencer;

  localparam int unsigned LAMPS    = 3;
  localparam int unsigned TICK_DIV = 4;

  localparam logic [6:0] S_DASH = 7'b0111111;
  localparam logic [6:0] S_L    = 7'b1000111;
  localparam logic [6:0] S_R    = 7'b0101111;
  localparam logic [6:0] S_H    = 7'b0001001;

  logic             clk = 1'b0;
  logic             reset;
  logic             left_req;
  logic             right_req;
  logic             hazard_req;
  logic [LAMPS-1:0] lamp_l;
  logic [LAMPS-1:0] lamp_r;
  logic [6:0]       seg;

  int passed = 0;
  int total  = 0;
  bit checking = 1'b0;

  tbird_light_sequencer #(.LAMPS(LAMPS), .TICK_DIV(TICK_DIV)) dut (
    .clk        (clk),
    .reset      (reset),
    .left_req   (left_req),
    .right_req  (right_req),
    .hazard_req (hazard_req),
    .lamp_l     (lamp_l),
    .lamp_r     (lamp_r),
    .seg        (seg)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: mode 0=idle 1=left 2=right 3=hazard; m_cnt counts cycles
  // since the current mode was entered, so step is just m_cnt / TICK_DIV.
  int         m_mode = 0;
  int         m_cnt  = 0;
  logic [2:0] e_l;
  logic [2:0] e_r;
  logic [6:0] e_seg;

  always @(posedge clk) begin : model
    int st;
    int rq;
    if (reset) begin
      e_l = '0; e_r = '0; e_seg = S_DASH;
      m_mode = 0; m_cnt = 0;
    end else begin
      case (m_mode)
        1: begin
          st = (m_cnt / TICK_DIV) % (LAMPS + 1);
          e_l = 3'((1 << st) - 1); e_r = '0; e_seg = S_L;
        end
        2: begin
          st = (m_cnt / TICK_DIV) % (LAMPS + 1);
          e_r = 3'((1 << st) - 1); e_l = '0; e_seg = S_R;
        end
        3: begin
          st = (m_cnt / TICK_DIV) % 2;
          e_l = (st != 0) ? 3'b111 : 3'b000; e_r = e_l; e_seg = S_H;
        end
        default: begin
          e_l = '0; e_r = '0; e_seg = S_DASH;
        end
      endcase
      if (hazard_req || (left_req && right_req)) rq = 3;
      else if (left_req) rq = 1;
      else if (right_req) rq = 2;
      else rq = 0;
      if (rq != m_mode) begin
        m_mode = rq; m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end
  end

  // Every-cycle comparison against the model, sampled on the falling edge.
  always @(negedge clk) begin
    if (checking) begin
      check("model_lamp_l", 32'(lamp_l), 32'(e_l));
      check("model_lamp_r", 32'(lamp_r), 32'(e_r));
      check("model_seg", 32'(seg), 32'(e_seg));
    end
  end

  logic [2:0] sweep_tab [5];

  initial begin
    sweep_tab = '{3'b000, 3'b001, 3'b011, 3'b111, 3'b000};
    reset = 1'b1; left_req = 1'b0; right_req = 1'b0; hazard_req = 1'b0;

    // Reset state after one edge
    wait_cyc(1);
    check("rst_lamp_l", 32'(lamp_l), 32'd0);
    check("rst_lamp_r", 32'(lamp_r), 32'd0);
    check("rst_seg", 32'(seg), 32'(S_DASH));
    checking = 1'b1;
    reset = 1'b0;
    wait_cyc(50);
    check("idle_hold_seg", 32'(seg), 32'(S_DASH));
    check("idle_hold_lamp_l", 32'(lamp_l), 32'd0);

    // Left sweep, each value held 4 cycles
    left_req = 1'b1;
    wait_cyc(2);
    check("left_seg", 32'(seg), 32'(S_L));
    check("left_step0", 32'(lamp_l), 32'(sweep_tab[0]));
    for (int i = 1; i < 5; i++) begin
      wait_cyc(4);
      check("left_sweep", 32'(lamp_l), 32'(sweep_tab[i]));
      check("left_r_off", 32'(lamp_r), 32'd0);
    end
    wait_cyc(20);
    left_req = 1'b0;
    wait_cyc(3);

    // Right sweep
    right_req = 1'b1;
    wait_cyc(2);
    check("right_seg", 32'(seg), 32'(S_R));
    check("right_step0", 32'(lamp_r), 32'd0);
    for (int i = 1; i < 5; i++) begin
      wait_cyc(4);
      check("right_sweep", 32'(lamp_r), 32'(sweep_tab[i]));
      check("right_l_off", 32'(lamp_l), 32'd0);
    end
    wait_cyc(10);
    right_req = 1'b0;
    wait_cyc(3);

    // Hazard from both turn switches
    left_req = 1'b1; right_req = 1'b1;
    wait_cyc(2);
    check("haz2_seg", 32'(seg), 32'(S_H));
    check("haz2_off", 32'({lamp_l, lamp_r}), 32'd0);
    wait_cyc(4);
    check("haz2_on", 32'({lamp_l, lamp_r}), 32'h3f);
    wait_cyc(4);
    check("haz2_off2", 32'({lamp_l, lamp_r}), 32'd0);
    wait_cyc(8);
    left_req = 1'b0; right_req = 1'b0;
    wait_cyc(3);

    // Hazard switch alone
    hazard_req = 1'b1;
    wait_cyc(2);
    check("haz_seg", 32'(seg), 32'(S_H));
    wait_cyc(4);
    check("haz_on", 32'({lamp_l, lamp_r}), 32'h3f);
    wait_cyc(10);
    hazard_req = 1'b0;
    wait_cyc(3);

    // Left to right mid-sweep
    left_req = 1'b1;
    wait_cyc(10);
    check("sw_pre", 32'(lamp_l), 32'd3);
    left_req = 1'b0; right_req = 1'b1;
    wait_cyc(2);
    check("sw_l_clear", 32'(lamp_l), 32'd0);
    check("sw_r_step0", 32'(lamp_r), 32'd0);
    wait_cyc(3);
    check("sw_r_still0", 32'(lamp_r), 32'd0);
    wait_cyc(1);
    check("sw_r_step1", 32'(lamp_r), 32'd1);
    wait_cyc(10);
    right_req = 1'b0;
    wait_cyc(3);

    // Reset pulse while all left lamps lit
    left_req = 1'b1;
    wait_cyc(14);
    check("rp_pre", 32'(lamp_l), 32'd7);
    reset = 1'b1;
    wait_cyc(1);
    check("rp_clear_l", 32'(lamp_l), 32'd0);
    check("rp_clear_seg", 32'(seg), 32'(S_DASH));
    reset = 1'b0;
    wait_cyc(2);
    check("rp_restart_seg", 32'(seg), 32'(S_L));
    wait_cyc(3);
    check("rp_still0", 32'(lamp_l), 32'd0);
    wait_cyc(1);
    check("rp_step1", 32'(lamp_l), 32'd1);

    // One-cycle hazard glitch during a left sweep forces a restart
    wait_cyc(7);
    hazard_req = 1'b1;
    wait_cyc(1);
    hazard_req = 1'b0;
    wait_cyc(1);
    check("glitch_seg_h", 32'(seg), 32'(S_H));
    wait_cyc(1);
    check("glitch_seg_l", 32'(seg), 32'(S_L));
    check("glitch_step0", 32'(lamp_l), 32'd0);
    wait_cyc(4);
    check("glitch_step1", 32'(lamp_l), 32'd1);
    wait_cyc(40);

    checking = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
